// File: rtl/shift_sweep_ctrl.sv
// Sweep sequencer for a combinational shifter: steps amt 1..2^AW-1,
// holds each value HOLD cycles, captures y and folds it into a signature.
module shift_sweep_ctrl #(
  parameter int W    = 8,
  parameter int AW   = 3,
  parameter int HOLD = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  input  logic [W-1:0]  a_in,
  input  logic          choice_in,
  output logic [W-1:0]  a,
  output logic [AW-1:0] amt,
  output logic          choice,
  input  logic [W-1:0]  y,
  output logic          res_valid,
  output logic [W-1:0]  res_y,
  output logic [AW-1:0] res_amt,
  output logic [W-1:0]  sig,
  output logic          busy,
  output logic          done
);

  localparam logic [AW-1:0] AMT_MAX   = '1;
  localparam logic [7:0]    HOLD_LAST = 8'(HOLD - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  a_q, a_d;
  logic [AW-1:0] amt_q, amt_d;
  logic          choice_q, choice_d;
  logic [7:0]    hold_q, hold_d;
  logic          res_valid_q, res_valid_d;
  logic [W-1:0]  res_y_q, res_y_d;
  logic [AW-1:0] res_amt_q, res_amt_d;
  logic [W-1:0]  sig_q, sig_d;
  logic          done_q, done_d;

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    amt_d       = amt_q;
    choice_d    = choice_q;
    hold_d      = hold_q;
    res_valid_d = 1'b0;
    res_y_d     = res_y_q;
    res_amt_d   = res_amt_q;
    sig_d       = sig_q;
    done_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d  = RUN;
          a_d      = a_in;
          choice_d = choice_in;
          amt_d    = AW'(1);
          sig_d    = '0;
          hold_d   = '0;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
          amt_d   = '0;
        end else if (hold_q < HOLD_LAST) begin
          hold_d = hold_q + 8'd1;
        end else begin
          // End of hold window: y has been stable at least one cycle
          res_valid_d = 1'b1;
          res_y_d     = y;
          res_amt_d   = amt_q;
          sig_d       = sig_q ^ y;
          hold_d      = '0;
          if (amt_q == AMT_MAX) begin
            state_d = IDLE;
            amt_d   = '0;
            done_d  = 1'b1;
          end else begin
            amt_d = amt_q + AW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      a_q         <= '0;
      amt_q       <= '0;
      choice_q    <= 1'b0;
      hold_q      <= '0;
      res_valid_q <= 1'b0;
      res_y_q     <= '0;
      res_amt_q   <= '0;
      sig_q       <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      amt_q       <= amt_d;
      choice_q    <= choice_d;
      hold_q      <= hold_d;
      res_valid_q <= res_valid_d;
      res_y_q     <= res_y_d;
      res_amt_q   <= res_amt_d;
      sig_q       <= sig_d;
      done_q      <= done_d;
    end
  end

  assign a         = a_q;
  assign amt       = amt_q;
  assign choice    = choice_q;
  assign res_valid = res_valid_q;
  assign res_y     = res_y_q;
  assign res_amt   = res_amt_q;
  assign sig       = sig_q;
  assign busy      = (state_q == RUN);
  assign done      = done_q;

endmodule

// File: tb/tb_shift_sweep_ctrl.sv
// Directed bench for shift_sweep_ctrl: HOLD=1 unit with a real shifter
// model, HOLD=3 unit with y tied to a constant.
module tb_shift_sweep_ctrl;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int n_run  = 0;
  int n_fail = 0;

  // HOLD=1 unit, real shifter (choice 0 = left, 1 = right)
  logic       start1, abort1, choice_in1;
  logic [7:0] a_in1, a1, y1, ry1, sig1;
  logic [2:0] amt1, ramt1;
  logic       choice1, rv1, busy1, done1;

  assign y1 = choice1 ? (a1 >> amt1) : (a1 << amt1);

  shift_sweep_ctrl #(.W(8), .AW(3), .HOLD(1)) u1 (
    .clk(clk), .reset(reset), .start(start1), .abort(abort1),
    .a_in(a_in1), .choice_in(choice_in1),
    .a(a1), .amt(amt1), .choice(choice1), .y(y1),
    .res_valid(rv1), .res_y(ry1), .res_amt(ramt1),
    .sig(sig1), .busy(busy1), .done(done1)
  );

  // HOLD=3 unit, y forced
  logic       start3, abort3, choice_in3;
  logic [7:0] a_in3, a3, y3, ry3, sig3;
  logic [2:0] amt3, ramt3;
  logic       choice3, rv3, busy3, done3;

  shift_sweep_ctrl #(.W(8), .AW(3), .HOLD(3)) u3 (
    .clk(clk), .reset(reset), .start(start3), .abort(abort3),
    .a_in(a_in3), .choice_in(choice_in3),
    .a(a3), .amt(amt3), .choice(choice3), .y(y3),
    .res_valid(rv3), .res_y(ry3), .res_amt(ramt3),
    .sig(sig3), .busy(busy3), .done(done3)
  );

  function automatic logic [7:0] shf(input logic [7:0] v,
                                     input int s,
                                     input logic ch);
    return ch ? (v >> s) : (v << s);
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] esig;
  int         nv;

  initial begin
    reset = 1'b1;
    start1 = 0; abort1 = 0; a_in1 = 0; choice_in1 = 0;
    start3 = 0; abort3 = 0; a_in3 = 0; choice_in3 = 0;
    y3 = 8'hA5;
    #2;
    chk("rst_a", a1, 0);
    chk("rst_amt", amt1, 0);
    chk("rst_choice", choice1, 0);
    chk("rst_rv", rv1, 0);
    chk("rst_ry", ry1, 0);
    chk("rst_ramt", ramt1, 0);
    chk("rst_sig", sig1, 0);
    chk("rst_busy", busy1, 0);
    chk("rst_done", done1, 0);
    chk("rst_busy3", busy3, 0);
    tick();
    reset = 1'b0;
    tick();

    // Full HOLD=1 sweep, left shift of D7
    a_in1 = 8'hD7; choice_in1 = 0; start1 = 1;
    tick();
    start1 = 0;
    esig = 8'h00;
    for (int k = 1; k <= 7; k++) begin
      chk("s2_busy", busy1, 1);
      chk("s2_amt", amt1, k);
      tick();
      esig = esig ^ shf(8'hD7, k, 1'b0);
      chk("s2_rv", rv1, 1);
      chk("s2_ramt", ramt1, k);
      chk("s2_ry", ry1, shf(8'hD7, k, 1'b0));
      chk("s2_done", done1, (k == 7));
    end
    chk("s2_sig_model", sig1, esig);
    chk("s2_sig_hand", sig1, 8'h9A);
    chk("s2_busy_end", busy1, 0);
    chk("s2_amt_end", amt1, 0);
    tick();
    chk("s2_rv_low", rv1, 0);
    chk("s2_done_low", done1, 0);

    // Abort after the amt=3 capture, right shift of B4
    a_in1 = 8'hB4; choice_in1 = 1; start1 = 1;
    tick();
    start1 = 0;
    tick(); tick(); tick();
    chk("s4_ramt3", ramt1, 3);
    abort1 = 1;
    tick();
    abort1 = 0;
    chk("s4_busy", busy1, 0);
    chk("s4_amt", amt1, 0);
    chk("s4_rv", rv1, 0);
    chk("s4_done", done1, 0);
    chk("s4_sig", sig1, 8'h61);
    chk("s4_a", a1, 8'hB4);
    chk("s4_choice", choice1, 1);
    nv = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (rv1 || done1) nv++;
    end
    chk("s4_no_strobe", nv, 0);
    chk("s4_sig_hold", sig1, 8'h61);

    // start+abort in IDLE: abort wins
    a_in1 = 8'h11; choice_in1 = 0; start1 = 1; abort1 = 1;
    tick();
    start1 = 0; abort1 = 0;
    chk("s6_busy", busy1, 0);
    chk("s6_a", a1, 8'hB4);
    chk("s6_choice", choice1, 1);
    tick();
    chk("s6_busy2", busy1, 0);

    // start held through a whole sweep
    a_in1 = 8'h3C; choice_in1 = 0; start1 = 1;
    tick();
    for (int k = 1; k <= 7; k++) begin
      chk("s5_busy", busy1, 1);
      chk("s5_amt", amt1, k);
      tick();
    end
    chk("s5_done", done1, 1);
    chk("s5_busy_gap", busy1, 0);
    tick();
    chk("s5_restart_busy", busy1, 1);
    chk("s5_restart_amt", amt1, 1);
    chk("s5_done_low", done1, 0);
    start1 = 0; abort1 = 1;
    tick();
    abort1 = 0;
    chk("s5_abort_busy", busy1, 0);

    // Asynchronous reset mid-sweep at amt=4
    a_in1 = 8'hD7; choice_in1 = 0; start1 = 1;
    tick();
    start1 = 0;
    tick(); tick(); tick();
    chk("s1_amt4", amt1, 4);
    reset = 1'b1;
    #1;
    chk("s1_async_amt", amt1, 0);
    chk("s1_async_busy", busy1, 0);
    chk("s1_async_a", a1, 0);
    chk("s1_async_sig", sig1, 0);
    chk("s1_async_ry", ry1, 0);
    chk("s1_async_ramt", ramt1, 0);
    tick();
    reset = 1'b0;
    a_in1 = 8'h81; start1 = 1;
    tick();
    start1 = 0;
    chk("s1_new_busy", busy1, 1);
    chk("s1_new_amt", amt1, 1);
    chk("s1_new_a", a1, 8'h81);
    abort1 = 1;
    tick();
    abort1 = 0;

    // HOLD=3 sweep with y forced to A5
    a_in3 = 8'h5A; start3 = 1;
    tick();
    start3 = 0;
    nv = 0;
    for (int t = 1; t <= 21; t++) begin
      chk("s3_busy", busy3, 1);
      tick();
      chk("s3_rv", rv3, (t % 3 == 0));
      if (rv3) begin
        nv++;
        chk("s3_ry", ry3, 8'hA5);
        chk("s3_ramt", ramt3, nv);
      end
    end
    chk("s3_nvalid", nv, 7);
    chk("s3_done", done3, 1);
    chk("s3_busy_end", busy3, 0);
    chk("s3_sig", sig3, 8'hA5);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
